// File: rtl/pic_fetch_unit.sv
// pic_fetch_unit: PIC-style fetch stage with the PC, a one-cycle redirect bubble, the return stack and goto-$ halt detection.
// Define PIC_FETCH_STACK_EN to build the hardware return stack; without it, call acts as goto and ret only flags underflow.
module pic_fetch_unit #(
    parameter int          STACK_DEPTH = 8,
    parameter logic [13:0] NOP_WORD    = 14'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] Rom_addr_out,
    input  logic [13:0] Rom_data_in,
    output logic [13:0] ir_out,
    output logic [10:0] ir_pc,
    output logic        ir_valid,
    input  logic        stall,
    input  logic        branch_req,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic        skip_req,
    input  logic [10:0] target,
    output logic        stk_ovf,
    output logic        stk_unf,
    output logic        halted
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t      state_q, state_d;
    logic [10:0] pc_q, pc_d, ir_pc_q, ir_pc_d, dest;
    logic [13:0] ir_q, ir_d;
    logic        valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d, halt_q, halt_d;
    logic        act, do_ret, do_call, do_br, do_skip, self_loop, redirect, ovf_set, unf_set;

    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("STACK_DEPTH must be a power of two >= 2");
    end

    assign act       = valid_q & ~stall;
    assign do_ret    = act & ret_req;
    assign do_call   = act & ~ret_req & call_req;
    assign do_br     = act & ~ret_req & ~call_req & branch_req;
    assign do_skip   = act & ~ret_req & ~call_req & ~branch_req & skip_req;
    assign self_loop = do_br && ir_q[13:11] == 3'b101 && ir_q[10:0] == ir_pc_q;

`ifdef PIC_FETCH_STACK_EN
    localparam int          AW   = $clog2(STACK_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(STACK_DEPTH);

    logic [10:0]   stk_q [STACK_DEPTH];
    logic [AW-1:0] sp_q;
    logic [AW:0]   cnt_q;
    logic          empty, full;

    assign empty    = cnt_q == '0;
    assign full     = cnt_q == FULL;
    assign redirect = do_ret | do_call | do_br;
    assign dest     = do_ret ? (empty ? 11'h000 : stk_q[sp_q - 1'b1]) : target;
    assign ovf_set  = do_call & full;
    assign unf_set  = do_ret & empty;

    // Circular buffer: a push onto a full stack lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (do_call) stk_q[sp_q] <= pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (do_call) begin
            sp_q  <= sp_q + 1'b1;
            cnt_q <= full ? cnt_q : cnt_q + 1'b1;
        end else if (do_ret && !empty) begin
            sp_q  <= sp_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end
`else
    assign redirect = do_call | do_br;
    assign dest     = target;
    assign ovf_set  = 1'b0;
    assign unf_set  = do_ret;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        ovf_d   = ovf_q | ovf_set;
        unf_d   = unf_q | unf_set;
        if (!stall && state_q != HALT) begin
            if (self_loop) begin
                pc_d    = target;
                ir_d    = NOP_WORD;
                valid_d = 1'b0;
                halt_d  = 1'b1;
                state_d = HALT;
            end else if (redirect || do_skip) begin
                pc_d    = redirect ? dest : pc_q + 11'd1;
                ir_d    = NOP_WORD;
                valid_d = 1'b0;
                state_d = FLUSH;
            end else begin
                ir_d    = Rom_data_in;
                ir_pc_d = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + 11'd1;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= '0;
            ir_q    <= NOP_WORD;
            ir_pc_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            halt_q  <= halt_d;
        end
    end

    assign Rom_addr_out = pc_q;
    assign ir_out       = ir_q;
    assign ir_pc        = ir_pc_q;
    assign ir_valid     = valid_q;
    assign stk_ovf      = ovf_q;
    assign stk_unf      = unf_q;
    assign halted       = halt_q;
endmodule

// File: tb/tb_pic_fetch_unit.sv
// tb_pic_fetch_unit: directed checks of fetch, skip, call/ret, stack limits, halt, PC wrap and stall.
module tb_pic_fetch_unit;
    logic        clk, rst_n;
    logic [10:0] Rom_addr_out, ir_pc, target;
    logic [13:0] Rom_data_in, ir_out;
    logic        ir_valid, stall, branch_req, call_req, ret_req, skip_req;
    logic        stk_ovf, stk_unf, halted;
    logic [13:0] rom [2048];
    int          n_chk = 0;
    int          n_fail = 0;

    pic_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .Rom_addr_out(Rom_addr_out), .Rom_data_in(Rom_data_in),
        .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .stall(stall),
        .branch_req(branch_req), .call_req(call_req), .ret_req(ret_req), .skip_req(skip_req),
        .target(target), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .halted(halted)
    );

    assign Rom_data_in = rom[Rom_addr_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        {stall, branch_req, call_req, ret_req, skip_req} = '0;
        target = '0;
        tick();
    endtask

    task automatic run_to(input logic [10:0] a);
        for (int i = 0; i < 4096 && !(ir_valid && ir_pc == a); i++) tick();
        check("reach_pc", {ir_valid, ir_pc}, {1'b1, a});
    endtask

    task automatic redirect(input logic c, input logic [10:0] t, input logic [10:0] exp_addr);
        call_req = c;
        branch_req = ~c;
        target = t;
        tick();
        {call_req, branch_req} = '0;
        check("redir_bubble", ir_valid, 1'b0);
        check("redir_addr", Rom_addr_out, exp_addr);
        tick();
        check("redir_land", {ir_valid, ir_pc}, {1'b1, exp_addr});
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 14'h1000 | 14'(i);
        rom[0] = 14'h30FE;
        rom[1] = 14'h00A5;
        rom[2] = 14'h3002;
        rom[14] = 14'h280E;
        rst_n = 1'b0;

        reset_dut();
        check("rst_ir", ir_out, 14'h0000);
        check("rst_irpc", ir_pc, 11'h000);
        check("rst_valid", ir_valid, 1'b0);
        check("rst_addr", Rom_addr_out, 11'h000);
        check("rst_flags", {stk_ovf, stk_unf, halted}, 3'b000);
        rst_n = 1'b1;
        tick();
        check("e1", {ir_valid, ir_pc, ir_out}, {1'b1, 11'h000, 14'h30FE});
        tick();
        check("e2", {ir_valid, ir_pc, ir_out}, {1'b1, 11'h001, 14'h00A5});
        tick();
        check("e3", {ir_valid, ir_pc, ir_out}, {1'b1, 11'h002, 14'h3002});
        check("e3_addr", Rom_addr_out, 11'h003);

        run_to(11'h006);
        skip_req = 1'b1;
        tick();
        skip_req = 1'b0;
        check("skip_bubble", ir_valid, 1'b0);
        check("skip_addr", Rom_addr_out, 11'h008);
        tick();
        check("skip_land", {ir_valid, ir_pc, ir_out}, {1'b1, 11'h008, rom[8]});

        reset_dut();
        rst_n = 1'b1;
        run_to(11'h003);
        redirect(1'b1, 11'h040, 11'h040);
        tick();
        check("call_seq", ir_pc, 11'h041);
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
`ifdef PIC_FETCH_STACK_EN
        check("ret_bubble", ir_valid, 1'b0);
        check("ret_addr", Rom_addr_out, 11'h004);
        check("ret_unf", stk_unf, 1'b0);
        tick();
        check("ret_land", {ir_valid, ir_pc}, {1'b1, 11'h004});
`else
        check("ret_ignored", {ir_valid, ir_pc}, {1'b1, 11'h042});
        check("ret_unf", stk_unf, 1'b1);
`endif

        reset_dut();
        rst_n = 1'b1;
        run_to(11'h000);
        for (int i = 0; i < 9; i++) begin
            redirect(1'b1, 11'h100 + 11'(i * 16), 11'h100 + 11'(i * 16));
`ifdef PIC_FETCH_STACK_EN
            check("nest_ovf", stk_ovf, i == 8);
`else
            check("nest_ovf", stk_ovf, 1'b0);
`endif
        end
`ifdef PIC_FETCH_STACK_EN
        for (int j = 0; j < 8; j++) begin
            ret_req = 1'b1;
            tick();
            ret_req = 1'b0;
            check("nest_ret", Rom_addr_out, 11'h101 + 11'((7 - j) * 16));
            tick();
        end
        check("pre_unf", stk_unf, 1'b0);
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        check("empty_ret_addr", Rom_addr_out, 11'h000);
        check("empty_ret_unf", stk_unf, 1'b1);
`endif

        reset_dut();
        rst_n = 1'b1;
        run_to(11'h00E);
        check("goto_word", ir_out, 14'h280E);
        branch_req = 1'b1;
        target = 11'h00E;
        tick();
        check("halt_set", {halted, ir_valid, Rom_addr_out}, {1'b1, 1'b0, 11'h00E});
        skip_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold", {halted, ir_valid, Rom_addr_out}, {1'b1, 1'b0, 11'h00E});
        end
        {branch_req, skip_req} = '0;
        rst_n = 1'b0;
        #1;
        check("halt_async_rst", {halted, Rom_addr_out}, {1'b0, 11'h000});

        reset_dut();
        rst_n = 1'b1;
        run_to(11'h000);
        redirect(1'b0, 11'h7FF, 11'h7FF);
        check("wrap_addr", Rom_addr_out, 11'h000);
        check("wrap_ir", ir_out, rom[2047]);
        stall = 1'b1;
        skip_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {ir_valid, ir_pc, ir_out, Rom_addr_out}, {1'b1, 11'h7FF, rom[2047], 11'h000});
        end
        {stall, skip_req} = '0;
        tick();
        check("stall_release", {ir_valid, ir_pc, ir_out}, {1'b1, 11'h000, 14'h30FE});

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
